// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch history table with per-entry valid bit, tag, target and
// 2-bit saturating direction counter. The fetch stage looks up the table
// combinationally; the execute stage trains it with the resolved outcome and
// raises a registered one-cycle mispredict pulse plus the correct next PC.
//
// Parameters
//   BHT_DEPTH : number of table entries (power of two, 4..64)
//   PC_W      : width of program counters and targets
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : asynchronous active-low reset
//   if_valid       : fetch lookup request qualifier
//   if_pc          : fetch PC to predict
//   pred_taken     : predicted taken for if_pc
//   pred_target    : predicted next PC for if_pc
//   ex_valid       : resolved control-transfer instruction present in EX
//   ex_pc          : PC of the resolved instruction
//   ex_taken       : resolved direction
//   ex_target      : resolved target address
//   ex_pred_taken  : prediction carried down the pipe with the instruction
//   ex_pred_target : predicted next PC carried down the pipe
//   mispredict     : one-cycle flush pulse
//   redirect_pc    : correct next PC, held until the next mispredict
//   stat_branches    : (BP_STATS_EN only) count of resolved instructions
//   stat_mispredicts : (BP_STATS_EN only) count of detected mispredictions
//
// Optional feature: define BP_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int BHT_DEPTH = 16,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    logic             bht_valid  [BHT_DEPTH];
    logic [TAG_W-1:0] bht_tag    [BHT_DEPTH];
    logic [PC_W-1:0]  bht_target [BHT_DEPTH];
    logic [1:0]       bht_ctr    [BHT_DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_cur_ctr;
    logic [1:0]       ex_next_ctr;
    logic [PC_W-1:0]  correct_pc;
    logic             ex_error;

    // The two low PC bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0], ex_pred_taken};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

    // Fetch-side lookup reads the registered table directly, so an update in
    // flight this cycle is not visible until the following cycle. Gating with
    // rst keeps the prediction at fall-through while reset is held.
    assign if_hit      = rst && if_valid && bht_valid[if_idx] && (bht_tag[if_idx] == if_tag);
    assign pred_taken  = if_hit && bht_ctr[if_idx][1];
    assign pred_target = pred_taken ? bht_target[if_idx] : (if_pc + PC_STEP);

    assign ex_hit = bht_valid[ex_idx] && (bht_tag[ex_idx] == ex_tag);

    // The carried prediction is compared as a full next-PC, which catches both
    // a wrong direction and a wrong target with a single comparison.
    assign correct_pc = ex_taken ? ex_target : (ex_pc + PC_STEP);
    assign ex_error   = ex_valid && (ex_pred_target != correct_pc);

    // Saturating counter step for the entry being trained.
    always_comb begin
        ex_cur_ctr  = bht_ctr[ex_idx];
        ex_next_ctr = ex_cur_ctr;
        if (ex_taken) begin
            if (ex_cur_ctr != CTR_STRONG_T) begin
                ex_next_ctr = ex_cur_ctr + 2'b01;
            end
        end else begin
            if (ex_cur_ctr != CTR_STRONG_NT) begin
                ex_next_ctr = ex_cur_ctr - 2'b01;
            end
        end
    end

    // Table training: hits adjust the counter (and target on taken), taken
    // misses allocate a fresh weak-taken entry, not-taken misses are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_valid[i]  <= 1'b0;
                bht_tag[i]    <= '0;
                bht_target[i] <= '0;
                bht_ctr[i]    <= CTR_WEAK_NT;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                bht_ctr[ex_idx] <= ex_next_ctr;
                if (ex_taken) begin
                    bht_target[ex_idx] <= ex_target;
                end
            end else if (ex_taken) begin
                bht_valid[ex_idx]  <= 1'b1;
                bht_tag[ex_idx]    <= ex_tag;
                bht_target[ex_idx] <= ex_target;
                bht_ctr[ex_idx]    <= CTR_WEAK_T;
            end
        end
    end

    // Redirect register: pulses for exactly one cycle per error and keeps the
    // last correct PC otherwise so downstream logic can sample it late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= ex_error;
            if (ex_error) begin
                redirect_pc <= correct_pc;
            end
        end
    end

`ifdef BP_STATS_EN
    // Free-running event counters; they wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (ex_valid) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (ex_error) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor (BHT_DEPTH=16, PC_W=32). A
// behavioural model of the table (plain arrays, integer counters clamped to
// 0..3) predicts every lookup and every redirect. Directed steps cover reset,
// allocation, counter decay, aliasing, same-cycle lookup and reset during an
// error cycle, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_val [DEPTH];
    logic [31:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_ctr [DEPTH];
    logic        exp_mis;
    logic [31:0] exp_redir;
    int          exp_branches;
    int          exp_errors;

    branch_predictor #(.BHT_DEPTH(DEPTH), .PC_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_val[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
            m_ctr[i] = 1;
        end
        exp_mis      = 1'b0;
        exp_redir    = '0;
        exp_branches = 0;
        exp_errors   = 0;
    endfunction

    function automatic void predict(input logic iv, input logic [31:0] pc,
                                    output logic t, output logic [31:0] tgt);
        int i;
        bit hit;
        i   = idx_of(pc);
        hit = (rst === 1'b1) && iv && m_val[i] && (m_tag[i] == (pc >> 6));
        t   = hit && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    // Applies the spec rules for one rising edge using the held inputs.
    function automatic void model_update();
        int          i;
        bit          hit;
        logic [31:0] correct;
        if (rst !== 1'b1) begin
            exp_mis = 1'b0;
        end else if (!ex_valid) begin
            exp_mis = 1'b0;
        end else begin
            i       = idx_of(ex_pc);
            hit     = m_val[i] && (m_tag[i] == (ex_pc >> 6));
            correct = ex_taken ? ex_target : ex_pc + 32'd4;
            exp_mis = (ex_pred_target != correct);
            if (exp_mis) begin
                exp_redir  = correct;
                exp_errors = exp_errors + 1;
            end
            exp_branches = exp_branches + 1;
            if (hit) begin
                if (ex_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (ex_taken) begin
                m_val[i] = 1'b1;
                m_tag[i] = ex_pc >> 6;
                m_tgt[i] = ex_target;
                m_ctr[i] = 2;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // carry=1 sends the model's own prediction for ex_pc down the pipe,
    // carry=0 uses eptgt as a deliberately arbitrary carried prediction.
    task automatic applyStimulus(input logic iv, input logic [31:0] ipc,
                                 input logic ev, input logic [31:0] epc,
                                 input logic et, input logic [31:0] etgt,
                                 input bit carry, input logic [31:0] eptgt);
        logic        pt;
        logic [31:0] ptg;
        predict(1'b1, epc, pt, ptg);
        if_valid  = iv;
        if_pc     = ipc;
        ex_valid  = ev;
        ex_pc     = epc;
        ex_taken  = et;
        ex_target = etgt;
        if (carry) begin
            ex_pred_taken  = pt;
            ex_pred_target = ptg;
        end else begin
            ex_pred_taken  = (eptgt != epc + 32'd4);
            ex_pred_target = eptgt;
        end
    endtask

    // Checks the lookup mid-cycle, advances one edge, then checks redirect.
    task automatic cycle(input string tag);
        logic        t;
        logic [31:0] tg;
        #3;
        predict(if_valid, if_pc, t, tg);
        checkOutput({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, t});
        checkOutput({tag, "_pred_target"}, pred_target, tg);
        @(posedge clk);
        model_update();
        #1;
        checkOutput({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
        checkOutput({tag, "_redirect_pc"}, redirect_pc, exp_redir);
`ifdef BP_STATS_EN
        checkOutput({tag, "_stat_branches"}, stat_branches, 32'(exp_branches));
        checkOutput({tag, "_stat_mispredicts"}, stat_mispredicts, 32'(exp_errors));
`endif
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] bases [3];
        bases[0] = 32'h0000_0100;
        bases[1] = 32'h0000_1100;
        bases[2] = 32'hFFFF_FF80;
        return bases[$urandom_range(0, 2)] + ($urandom_range(0, 31) << 2);
    endfunction

    initial begin
        rst = 1'b0;
        model_reset();

        // Reset held: an erroneous resolution must be ignored entirely.
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        cycle("rst_hold0");
        cycle("rst_hold1");

        // Fall-through after reset, including PC wrap.
        rst = 1'b1;
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("after_reset");
        checkOutput("after_reset_pt_const", {31'd0, pred_taken}, 32'd0);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("pc_wrap");

        // Allocation on a taken miss, then a taken prediction.
        applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        cycle("alloc");
        checkOutput("alloc_mispredict_const", {31'd0, mispredict}, 32'd1);
        checkOutput("alloc_redirect_const", redirect_pc, 32'h80);
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        #3;
        checkOutput("alloc_lookup_pt_const", {31'd0, pred_taken}, 32'd1);
        checkOutput("alloc_lookup_tgt_const", pred_target, 32'h80);
        #2;
        checkOutput("alloc_redirect_held", redirect_pc, 32'h80);
        @(posedge clk);
        model_update();
        #1;

        // Four not-taken resolutions: counter decays 10->01->00->00.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0);
            cycle($sformatf("decay%0d", k));
            checkOutput($sformatf("decay%0d_pulse_const", k), {31'd0, mispredict},
                        (k == 0) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("decay_final");

        // Alias 0x140 shares the index of 0x100 and replaces it.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h140, 1'b1, 32'h200, 1'b1, 32'h0);
        cycle("alias_alloc");
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("alias_miss");
        checkOutput("alias_miss_tgt_const", pred_target, 32'h104);
        applyStimulus(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("alias_hit");

        // Same-cycle update and lookup of one index: lookup sees the old entry.
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h0);
        cycle("same_cycle");
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("same_cycle_next");

        // Reset asserted inside an error cycle: no pulse after release.
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 32'h184);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_err_redirect_clear", redirect_pc, 32'h0);
        checkOutput("rst_err_pred_taken", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_err_mispredict", {31'd0, mispredict}, 32'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("rst_err_release");

        // Three resolutions, one of them wrong.
        applyStimulus(1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("stats0");
        applyStimulus(1'b1, 32'h500, 1'b1, 32'h504, 1'b1, 32'h600, 1'b1, 32'h0);
        cycle("stats1");
        applyStimulus(1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h0);
        cycle("stats2");
`ifdef BP_STATS_EN
        checkOutput("stats_branches_const", stat_branches, 32'd3);
        checkOutput("stats_mispredicts_const", stat_mispredicts, 32'd1);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(($urandom_range(0, 3) != 0), pick_pc(),
                          ($urandom_range(0, 2) != 0), pick_pc(),
                          1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                          ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
